down_timer: RTL
===============

DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, count and load width in bits.
REQ-002 SHALL have parameter PRESC_DIV, default 4, clock cycles per decrement (legal range 1..256).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  level-sampled request to load load_val and begin the countdown.
REQ-006 SHALL have port pause  input  1  while high in RUN, freezes count and prescaler.
REQ-007 SHALL have port abort  input  1  cancels the countdown and returns to IDLE.
REQ-008 SHALL have port load_val  input  WIDTH  start value, sampled only on an accepted start.
REQ-009 SHALL have port q  output  WIDTH  current count, registered.
REQ-010 SHALL have port busy  output  1  high in RUN and PAUSE only, registered.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the count reaches 0, registered.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, PAUSE, DONE.
REQ-013 SHALL, in IDLE with start=1: q<=load_val, prescaler<=0, next RUN if load_val!=0, else DONE.
REQ-014 SHALL ignore start while in RUN, PAUSE or DONE (no restart, no reload).
REQ-015 SHALL, in RUN: prescaler increments each cycle; at PRESC_DIV-1 it wraps to 0 and q decrements by 1 (tick).
REQ-016 SHALL, on a tick with q==1: q<=0, next DONE; q SHALL never wrap below 0.
REQ-017 SHALL, in RUN with pause=1 (no abort): next PAUSE, q and prescaler held, no tick that cycle.
REQ-018 SHALL, in PAUSE: hold q and prescaler; pause=0 returns to RUN and the prescaler resumes from its held value.
REQ-019 SHALL, on abort=1 in RUN, PAUSE or DONE: next IDLE, q<=0, prescaler<=0, no done pulse issued after abort.
REQ-020 SHALL apply priority abort > pause > tick within RUN; abort > start within IDLE (abort in IDLE: q<=0).
REQ-021 SHALL assert done=1 exactly for the cycle spent in DONE; q reads 0 in that cycle.
REQ-022 SHALL, from DONE, go to IDLE next cycle (unless Configuration REQ-027 applies).
REQ-023 SHALL give latency: start sampled at edge N -> busy=1 and q=load_val after edge N; done after edge N+load_val*PRESC_DIV.
REQ-024 SHALL hold q in IDLE at its last value (0 after completion or abort).

Reset
REQ-025 SHALL, when reset=0 at a rising edge: state IDLE, q=0, prescaler=0, busy=0, done=0, overriding all other inputs.
REQ-026 SHALL abandon any countdown on reset mid-operation with no done pulse; start at the first edge with reset=1 is accepted normally.

Configuration
REQ-027 SHALL support macro DOWN_TIMER_AUTO_RELOAD_EN: when defined, DONE with no abort reloads q<=load_val (sampled in DONE), prescaler<=0, next RUN (next DONE if load_val==0, done pulsing every cycle); when undefined, DONE always goes to IDLE per REQ-022.

Verification
REQ-028 SHALL cover: reset=0 then start=1 load_val=3, PRESC_DIV=4 -> q 3,2,1,0 at 4-cycle steps, done high 1 cycle at cycle 13 after start edge, busy low after.
REQ-029 SHALL cover: start with load_val=0 -> done pulses the cycle after start, busy never high, q=0.
REQ-030 SHALL cover: load_val=5, pause high 10 cycles after 2nd decrement -> q holds 3 throughout, done delayed by exactly 10 cycles.
REQ-031 SHALL cover: load_val=200, abort at q=100 -> q=0, busy=0 next cycle, no done pulse; start during RUN ignored (q unaffected).
REQ-032 SHALL cover: reset=0 asserted mid-count at q=7 -> all outputs 0 next edge; simultaneous abort+start in IDLE -> stays IDLE.
REQ-033 SHALL cover: with DOWN_TIMER_AUTO_RELOAD_EN, load_val=2 -> done pulses every 9 cycles (8 RUN + 1 DONE) until abort.

Source files
------------

// File: rtl/down_timer.sv
// down_timer: loadable countdown timer with a clock prescaler.
// Four-state FSM (IDLE/RUN/PAUSE/DONE). Each decrement of q takes
// PRESC_DIV cycles; pause freezes both count and prescaler; abort cancels.
// Optional feature macro: DOWN_TIMER_AUTO_RELOAD_EN -- when defined, DONE
// reloads load_val and restarts instead of returning to IDLE.
module down_timer #(
  parameter int WIDTH     = 8,
  parameter int PRESC_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  // Prescaler needs at least one bit even when PRESC_DIV == 1.
  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             busy_q;
  logic             done_q;

  // Next-state logic: abort > pause > tick in RUN/PAUSE, abort > start in IDLE.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    case (state_q)
      ST_IDLE: begin
        if (abort) begin
          count_d = '0;
          presc_d = '0;
        end else if (start) begin
          count_d = load_val;
          presc_d = '0;
          state_d = (load_val != '0) ? ST_RUN : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      // PAUSE with pause released advances exactly like RUN, so the
      // countdown is delayed by precisely the number of paused cycles.
      ST_RUN, ST_PAUSE: begin
        if (abort) begin
          state_d = ST_IDLE;
          count_d = '0;
          presc_d = '0;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_RUN;
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (count_q <= WIDTH'(1)) begin
              count_d = '0;
              state_d = ST_DONE;
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      ST_DONE: begin
        if (abort) begin
          state_d = ST_IDLE;
          count_d = '0;
          presc_d = '0;
        end else begin
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
          count_d = load_val;
          presc_d = '0;
          state_d = (load_val != '0) ? ST_RUN : ST_DONE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
        presc_d = '0;
      end
    endcase
  end

  // State and output registers; busy/done are decoded from the next state
  // so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      presc_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      busy_q  <= (state_d == ST_RUN) || (state_d == ST_PAUSE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign q    = count_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
